// File: rtl/fmac_link_pkg.sv
// Shared types for the Fibre Channel link-state controller: link states,
// TX primitive selects, the default R_T_TOV length and the state-to-TX mapping.
package fmac_link_pkg;

  typedef enum logic [3:0] {AC, LR1, LR2, LR3, OL1, OL2, OL3, LF1, LF2} link_state_e;

  typedef enum logic [2:0] {TX_IDLE, TX_NOS, TX_OLS, TX_LR, TX_LRR} tx_prim_e;

  // 100 ms at 212.5 MHz
  localparam int RTTOV_CYC_DEFAULT = 21250000;

  function automatic tx_prim_e tx_for_state(input link_state_e s);
    tx_prim_e t;
    case (s)
      AC, LR1:  t = TX_IDLE;
      LR2:      t = TX_LRR;
      LR3, OL2: t = TX_LR;
      OL1, LF1: t = TX_OLS;
      default:  t = TX_NOS;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fmac_link_state_ctrl_if.sv
// Event/status bundle between the RX recognizers, software and the link-state
// controller. Stats signals exist only when FMAC_LINK_STATS_EN is defined.
interface fmac_link_state_ctrl_if
  import fmac_link_pkg::*;
`ifdef FMAC_LINK_STATS_EN
  #(parameter int STAT_W = 16)
`endif
  ;

  logic        nos_event;
  logic        ols_event;
  logic        lr_event;
  logic        lrr_event;
  logic        idle_event;
  logic        sync_lost;
  logic        link_reset_req;
  logic        offline_req;
  link_state_e link_state;
  tx_prim_e    tx_prim_sel;
  logic        link_up;
  logic        state_chg;
  logic        rttov_expired;
`ifdef FMAC_LINK_STATS_EN
  logic              stats_clr;
  logic [STAT_W-1:0] link_fail_cnt;
  logic [STAT_W-1:0] link_reset_cnt;

  modport master (
    output nos_event, ols_event, lr_event, lrr_event, idle_event,
           sync_lost, link_reset_req, offline_req, stats_clr,
    input  link_state, tx_prim_sel, link_up, state_chg, rttov_expired,
           link_fail_cnt, link_reset_cnt
  );

  modport slave (
    input  nos_event, ols_event, lr_event, lrr_event, idle_event,
           sync_lost, link_reset_req, offline_req, stats_clr,
    output link_state, tx_prim_sel, link_up, state_chg, rttov_expired,
           link_fail_cnt, link_reset_cnt
  );
`else
  modport master (
    output nos_event, ols_event, lr_event, lrr_event, idle_event,
           sync_lost, link_reset_req, offline_req,
    input  link_state, tx_prim_sel, link_up, state_chg, rttov_expired
  );

  modport slave (
    input  nos_event, ols_event, lr_event, lrr_event, idle_event,
           sync_lost, link_reset_req, offline_req,
    output link_state, tx_prim_sel, link_up, state_chg, rttov_expired
  );
`endif

endinterface

// File: rtl/fmac_rttov_timer.sv
// R_T_TOV timer: counts cycles while run is high, holds at the terminal count
// instead of wrapping, and flags expiry while sitting on the last count.
module fmac_rttov_timer
  import fmac_link_pkg::*;
#(
  parameter int RTTOV_CYC = RTTOV_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = $clog2(RTTOV_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RTTOV_CYC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr || !run) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is taken from the registered count so it never depends on clr.
  assign expired = run && (count_q == LAST);

endmodule

// File: rtl/fmac_link_state_ctrl.sv
// Fibre Channel port link-state controller (AC/LR1-3/OL1-3/LF1-2) driving the TX
// primitive select. Define FMAC_LINK_STATS_EN to add saturating fail/reset counters.
module fmac_link_state_ctrl
  import fmac_link_pkg::*;
#(
  parameter int RTTOV_CYC = RTTOV_CYC_DEFAULT
`ifdef FMAC_LINK_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fmac_link_state_ctrl_if.slave bus
);

  link_state_e state_q, state_d;
  tx_prim_e    tx_q;
  logic        link_up_q;
  logic        state_chg_q, state_chg_d;
  logic        rttov_q;
  logic        timed;
  logic        timeout;

  assign timed = (state_q == LR1) || (state_q == LR2) ||
                 (state_q == LR3) || (state_q == OL2);

  fmac_rttov_timer #(.RTTOV_CYC(RTTOV_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (timed),
    .clr     (state_chg_d),
    .expired (timeout)
  );

  // Within each state, events are tested in global priority order; an event
  // the state does not handle falls through so lower-priority ones still act.
  always_comb begin
    state_d = state_q;
    if (bus.sync_lost) begin
      state_d = LF2;
    end else if (timeout) begin
      state_d = LF2;
    end else begin
      case (state_q)
        AC: begin
          if      (bus.nos_event)      state_d = LF1;
          else if (bus.ols_event)      state_d = OL2;
          else if (bus.lr_event)       state_d = LR2;
          else if (bus.lrr_event)      state_d = LR1;
          else if (bus.offline_req)    state_d = OL1;
          else if (bus.link_reset_req) state_d = LR3;
        end
        LR3: begin
          if      (bus.nos_event) state_d = LF1;
          else if (bus.ols_event) state_d = OL2;
          else if (bus.lr_event)  state_d = LR2;
          else if (bus.lrr_event) state_d = LR1;
        end
        LR2: begin
          if      (bus.nos_event)  state_d = LF1;
          else if (bus.ols_event)  state_d = OL2;
          else if (bus.lrr_event)  state_d = LR1;
          else if (bus.idle_event) state_d = AC;
        end
        LR1: begin
          if      (bus.nos_event)  state_d = LF1;
          else if (bus.ols_event)  state_d = OL2;
          else if (bus.lr_event)   state_d = LR2;
          else if (bus.idle_event) state_d = AC;
        end
        OL1: begin
          if      (bus.nos_event) state_d = OL3;
          else if (bus.ols_event) state_d = OL2;
        end
        OL2: begin
          if      (bus.nos_event) state_d = OL3;
          else if (bus.lr_event)  state_d = LR2;
          else if (bus.lrr_event) state_d = LR1;
        end
        OL3: begin
          if (bus.ols_event) state_d = OL2;
        end
        LF1: begin
          if (bus.ols_event) state_d = OL2;
        end
        LF2: begin
          if      (bus.nos_event) state_d = LF1;
          else if (bus.ols_event) state_d = OL2;
        end
        default: state_d = LF2;
      endcase
    end
    state_chg_d = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LF2;
      tx_q        <= TX_NOS;
      link_up_q   <= 1'b0;
      state_chg_q <= 1'b0;
      rttov_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_for_state(state_d);
      link_up_q   <= (state_d == AC);
      state_chg_q <= state_chg_d;
      rttov_q     <= timeout;
    end
  end

  assign bus.link_state    = state_q;
  assign bus.tx_prim_sel   = tx_q;
  assign bus.link_up       = link_up_q;
  assign bus.state_chg     = state_chg_q;
  assign bus.rttov_expired = rttov_q;

`ifdef FMAC_LINK_STATS_EN
  logic [STAT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [STAT_W-1:0] reset_cnt_q, reset_cnt_d;
  logic              enter_fail;
  logic              enter_reset;

  assign enter_fail  = state_chg_d && ((state_d == LF1) || (state_d == LF2));
  assign enter_reset = state_chg_d &&
                       ((state_d == LR1) || (state_d == LR2) || (state_d == LR3));

  // Clear takes precedence over a coincident increment; counts stick at all-ones.
  always_comb begin
    fail_cnt_d  = fail_cnt_q;
    reset_cnt_d = reset_cnt_q;
    if (bus.stats_clr) begin
      fail_cnt_d  = '0;
      reset_cnt_d = '0;
    end else begin
      if (enter_fail && (fail_cnt_q != '1))   fail_cnt_d  = fail_cnt_q + STAT_W'(1);
      if (enter_reset && (reset_cnt_q != '1)) reset_cnt_d = reset_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_q  <= '0;
      reset_cnt_q <= '0;
    end else begin
      fail_cnt_q  <= fail_cnt_d;
      reset_cnt_q <= reset_cnt_d;
    end
  end

  assign bus.link_fail_cnt  = fail_cnt_q;
  assign bus.link_reset_cnt = reset_cnt_q;
`endif

endmodule

// File: tb/tb_fmac_link_state_ctrl.sv
// Self-checking bench for fmac_link_state_ctrl (RTTOV_CYC=16); expected
// outputs are queued as each stimulus cycle is driven and checked after the edge.
module tb_fmac_link_state_ctrl;
  import fmac_link_pkg::*;

  typedef struct packed {
    link_state_e state;
    tx_prim_e    tx;
    logic        up;
    logic        chg;
    logic        exp;
  } expect_t;

  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_NOS  = 5'b10000;
  localparam logic [4:0] EV_OLS  = 5'b01000;
  localparam logic [4:0] EV_LR   = 5'b00100;
  localparam logic [4:0] EV_LRR  = 5'b00010;
  localparam logic [4:0] EV_IDLE = 5'b00001;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  expect_t expQ[$];

  fmac_link_state_ctrl_if bus();

  fmac_link_state_ctrl #(.RTTOV_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Independent state-to-primitive table used to build expectations.
  function automatic tx_prim_e txOf(input link_state_e s);
    case (s)
      AC:      return TX_IDLE;
      LR1:     return TX_IDLE;
      LR2:     return TX_LRR;
      LR3:     return TX_LR;
      OL1:     return TX_OLS;
      OL2:     return TX_LR;
      OL3:     return TX_NOS;
      LF1:     return TX_OLS;
      default: return TX_NOS;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".state"}, 32'(bus.link_state), 32'(LF2));
    checkOutput({tag, ".tx"}, 32'(bus.tx_prim_sel), 32'(TX_NOS));
    checkOutput({tag, ".linkUp"}, 32'(bus.link_up), 32'd0);
    checkOutput({tag, ".stateChg"}, 32'(bus.state_chg), 32'd0);
    checkOutput({tag, ".rttov"}, 32'(bus.rttov_expired), 32'd0);
  endtask

  task automatic checkDut();
    expect_t e;
    checkOutput("sbDepth", 32'(expQ.size()), 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("state", 32'(bus.link_state), 32'(e.state));
      checkOutput("tx", 32'(bus.tx_prim_sel), 32'(e.tx));
      checkOutput("linkUp", 32'(bus.link_up), 32'(e.up));
      checkOutput("stateChg", 32'(bus.state_chg), 32'(e.chg));
      checkOutput("rttov", 32'(bus.rttov_expired), 32'(e.exp));
    end
  endtask

  // Drive one cycle of event pulses, queue the expected registered result,
  // then compare just after the clock edge that should produce it.
  task automatic applyStimulus(input logic [4:0] ev, input link_state_e st,
                               input logic chg, input logic exp);
    expect_t e;
    {bus.nos_event, bus.ols_event, bus.lr_event, bus.lrr_event, bus.idle_event} = ev;
    e.state = st;
    e.tx    = txOf(st);
    e.up    = (st == AC);
    e.chg   = chg;
    e.exp   = exp;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    {bus.nos_event, bus.ols_event, bus.lr_event, bus.lrr_event, bus.idle_event} = EV_NONE;
    checkDut();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.nos_event      = 1'b0;
    bus.ols_event      = 1'b0;
    bus.lr_event       = 1'b0;
    bus.lrr_event      = 1'b0;
    bus.idle_event     = 1'b0;
    bus.sync_lost      = 1'b1;
    bus.link_reset_req = 1'b0;
    bus.offline_req    = 1'b0;
`ifdef FMAC_LINK_STATS_EN
    bus.stats_clr      = 1'b0;
`endif
    #12;
    checkReset("reset");
    tick();
    rst_n = 1'b1;

    $display("[TB] Out of sync after reset, then OLS");
    for (int i = 0; i < 10; i++) applyStimulus(EV_NONE, LF2, 1'b0, 1'b0);
    bus.sync_lost = 1'b0;
    applyStimulus(EV_OLS, OL2, 1'b1, 1'b0);

    $display("[TB] OL2 -> LR1 -> AC");
    applyStimulus(EV_LRR, LR1, 1'b1, 1'b0);
    applyStimulus(EV_IDLE, AC, 1'b1, 1'b0);
    applyStimulus(EV_NONE, AC, 1'b0, 1'b0);

    $display("[TB] Software link reset, R_T_TOV expiry");
    bus.link_reset_req = 1'b1;
    applyStimulus(EV_NONE, LR3, 1'b1, 1'b0);
    bus.link_reset_req = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(EV_NONE, LR3, 1'b0, 1'b0);
    applyStimulus(EV_NONE, LF2, 1'b1, 1'b1);
    applyStimulus(EV_NONE, LF2, 1'b0, 1'b0);

    $display("[TB] NOS beats LR, NOS ignored in LF1, sync loss");
    applyStimulus(EV_OLS, OL2, 1'b1, 1'b0);
    applyStimulus(EV_LRR, LR1, 1'b1, 1'b0);
    applyStimulus(EV_IDLE, AC, 1'b1, 1'b0);
    applyStimulus(EV_NOS | EV_LR, LF1, 1'b1, 1'b0);
    applyStimulus(EV_NOS, LF1, 1'b0, 1'b0);
    bus.sync_lost = 1'b1;
    applyStimulus(EV_NONE, LF2, 1'b1, 1'b0);
    bus.sync_lost = 1'b0;

    $display("[TB] Offline request path");
    applyStimulus(EV_OLS, OL2, 1'b1, 1'b0);
    applyStimulus(EV_LRR, LR1, 1'b1, 1'b0);
    applyStimulus(EV_IDLE, AC, 1'b1, 1'b0);
    bus.offline_req    = 1'b1;
    bus.link_reset_req = 1'b1;
    applyStimulus(EV_NONE, OL1, 1'b1, 1'b0);
    applyStimulus(EV_NONE, OL1, 1'b0, 1'b0);
    bus.offline_req    = 1'b0;
    bus.link_reset_req = 1'b0;
    applyStimulus(EV_NOS, OL3, 1'b1, 1'b0);
    applyStimulus(EV_LR, OL3, 1'b0, 1'b0);
    applyStimulus(EV_OLS, OL2, 1'b1, 1'b0);

    $display("[TB] Async reset in LR2");
    applyStimulus(EV_LR, LR2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("asyncRst");
    tick();
    checkReset("heldRst");
    rst_n = 1'b1;

`ifdef FMAC_LINK_STATS_EN
    $display("[TB] Statistics counters");
    tick();
    checkOutput("failCntRst", 32'(bus.link_fail_cnt), 32'd0);
    checkOutput("resetCntRst", 32'(bus.link_reset_cnt), 32'd0);
    for (int i = 0; i < 32767; i++) begin
      bus.nos_event = 1'b1;
      bus.sync_lost = 1'b0;
      tick();
      bus.nos_event = 1'b0;
      bus.sync_lost = 1'b1;
      tick();
    end
    checkOutput("failCntFffe", 32'(bus.link_fail_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      bus.nos_event = (i != 1);
      bus.sync_lost = (i == 1);
      tick();
    end
    bus.nos_event = 1'b0;
    checkOutput("failCntSat", 32'(bus.link_fail_cnt), 32'hFFFF);
    bus.sync_lost = 1'b1;
    bus.stats_clr = 1'b1;
    tick();
    bus.stats_clr = 1'b0;
    bus.sync_lost = 1'b0;
    checkOutput("failCntClr", 32'(bus.link_fail_cnt), 32'd0);
    checkOutput("clrState", 32'(bus.link_state), 32'(LF2));
    bus.ols_event = 1'b1;
    tick();
    bus.ols_event = 1'b0;
    bus.lr_event  = 1'b1;
    tick();
    bus.lr_event  = 1'b0;
    checkOutput("resetCntInc", 32'(bus.link_reset_cnt), 32'd1);
    checkOutput("failCntHold", 32'(bus.link_fail_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
